// File: rtl/svc_uart_tx_arb.sv
// svc_uart_tx_arb
// Round-robin arbiter that merges NUM_REQ byte streams onto one UART TX byte
// interface through a single-entry output register.
//
// Build option: define SVC_UART_TX_ARB_LOCK_EN to enable message locking. Once
// a requester has a byte accepted with req_last=0, only that requester is
// eligible until it delivers a byte with req_last=1. Without the macro the
// arbiter picks a new owner for every byte and req_last is ignored.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid[i]      requester i has a byte
//   req_data[8i+:8]   requester i byte
//   req_last[i]       requester i byte ends its message
//   req_ready[i]      requester i byte accepted this cycle (at most one bit high)
//   utx_valid/data    registered byte toward svc_uart_tx
//   utx_ready         svc_uart_tx accepts the byte
//   grant_id          requester index that sourced utx_data
//   busy              output byte pending or message lock held

module svc_uart_tx_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GRANT_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 utx_valid,
    output logic [7:0]           utx_data,
    input  logic                 utx_ready,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 busy
);

`ifdef SVC_UART_TX_ARB_LOCK_EN
    localparam logic LockEn = 1'b1;
`else
    localparam logic LockEn = 1'b0;
`endif

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic               r_valid;
    logic [7:0]         r_data;
    logic [GRANT_W-1:0] r_gid;
    logic [GRANT_W-1:0] r_ptr;    // index where the next search starts
    logic [GRANT_W-1:0] r_owner;  // lock owner, meaningful only in ST_LOCK
    logic [0:0]         r_state;

    logic               w_free;
    logic               w_found;
    logic               w_accept;
    logic [GRANT_W-1:0] w_sel;
    logic [7:0]         w_byte;
    logic               w_last;
    logic [GRANT_W-1:0] w_ptr_nxt;
    logic [0:0]         w_state_nxt;
    logic [GRANT_W-1:0] w_owner_nxt;
    int unsigned        w_idx;

    // Slot can take a new byte when empty or when it drains on this edge.
    assign w_free = !r_valid || utx_ready;

    // Rotating priority search; in lock only the owner may win.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_byte  = '0;
        w_last  = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx] &&
                (r_state == ST_ARB || GRANT_W'(w_idx) == r_owner)) begin
                w_found = 1'b1;
                w_sel   = GRANT_W'(w_idx);
                w_byte  = req_data[w_idx*8 +: 8];
                w_last  = req_last[w_idx];
            end
        end
    end

    // rst_n gates the handshake so req_ready drops as soon as reset asserts.
    assign w_accept = w_found && w_free && rst_n;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_sel == GRANT_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        if (w_accept && LockEn) begin
            w_state_nxt = w_last ? ST_ARB : ST_LOCK;
            w_owner_nxt = w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_state <= ST_ARB;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_byte;
                r_gid   <= w_sel;
                r_ptr   <= w_ptr_nxt;
            end else if (utx_ready) begin
                r_valid <= 1'b0;
            end
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign utx_valid = r_valid;
    assign utx_data  = r_data;
    assign grant_id  = r_gid;
    assign busy      = r_valid || (r_state == ST_LOCK);

endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// Directed bench for svc_uart_tx_arb (NUM_REQ=2). Stimulus threads push the
// bytes each requester offers and the byte order expected on the UART side;
// an independent monitor compares every utx handshake against that queue.

module tb_svc_uart_tx_arb;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned GRANT_W = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 utx_valid;
    logic [7:0]           utx_data;
    logic                 utx_ready;
    logic [GRANT_W-1:0]   grant_id;
    logic                 busy;

    svc_uart_tx_arb #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .utx_valid (utx_valid),
        .utx_data  (utx_data),
        .utx_ready (utx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] src0[$];   // {last, data}
    logic [8:0] src1[$];
    logic [8:0] exp_q[$];  // {grant_id, data}
    logic [1:0] en;
    logic [8:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive();
        req_valid[0]   = en[0] && (src0.size() > 0);
        req_data[7:0]  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
        req_last[0]    = (src0.size() > 0) ? src0[0][8] : 1'b0;
        req_valid[1]   = en[1] && (src1.size() > 0);
        req_data[15:8] = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
        req_last[1]    = (src1.size() > 0) ? src1[0][8] : 1'b0;
    endtask

    // One clock: sample the handshake mid-cycle, pop accepted bytes after the edge.
    task automatic tick();
        logic [1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (acc[0]) void'(src0.pop_front());
        if (acc[1]) void'(src1.pop_front());
        drive();
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        src0.delete();
        src1.delete();
        en = 2'b11;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        chk({name, " drain"}, exp_q.size() + src0.size() + src1.size(), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && utx_valid && utx_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: got byte 0x%0h grant %0d, expected no byte",
                         utx_data, grant_id);
            end else begin
                mon_e = exp_q.pop_front();
                if ({grant_id, utx_data} !== mon_e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got byte 0x%0h grant %0d, expected 0x%0h grant %0d",
                             utx_data, grant_id, mon_e[7:0], mon_e[8]);
                end
            end
        end
    end

    initial begin
        // Reset with both requesters valid
        rst_n     = 1'b0;
        utx_ready = 1'b0;
        en        = 2'b11;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        src0.push_back({1'b1, 8'h01});
        src1.push_back({1'b1, 8'h02});
        drive();
        #3;
        chk("reset req_valid", 32'(req_valid), 32'h3);
        chk("reset utx_valid", 32'(utx_valid), 0);
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset utx_data", 32'(utx_data), 0);
        chk("reset grant_id", 32'(grant_id), 0);
        src0.delete();
        src1.delete();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-byte latency
        utx_ready = 1'b1;
        src0.push_back({1'b1, 8'h41});
        exp_q.push_back({1'b0, 8'h41});
        drive();
        #1;
        chk("lat req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("lat utx_valid", 32'(utx_valid), 1);
        chk("lat utx_data", 32'(utx_data), 32'h41);
        chk("lat grant_id", 32'(grant_id), 0);
        chk("lat busy", 32'(busy), 1);
        tick();
        chk("lat utx_valid clear", 32'(utx_valid), 0);
        chk("lat busy clear", 32'(busy), 0);

        // Per-byte fairness
        rst_pulse();
        src0.push_back({1'b1, 8'h10});
        src0.push_back({1'b1, 8'h11});
        src1.push_back({1'b1, 8'h20});
        src1.push_back({1'b1, 8'h21});
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h21});
        drive();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fair no idle", 32'(utx_valid), 1);
            chk("fair grant", 32'(grant_id), 32'(i % 2));
        end
        tick();
        chk("fair end idle", 32'(utx_valid), 0);

        // Backpressure: pointer now starts at 0
        utx_ready = 1'b0;
        src0.push_back({1'b1, 8'h55});
        src1.push_back({1'b1, 8'h66});
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b1, 8'h66});
        drive();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp hold data", 32'(utx_data), 32'h55);
            chk("bp hold valid", 32'(utx_valid), 1);
            chk("bp req_ready", 32'(req_ready), 0);
            tick();
        end
        utx_ready = 1'b1;
        #1;
        chk("bp release ready", 32'(req_ready), 32'h2);
        tick();
        chk("bp next data", 32'(utx_data), 32'h66);
        chk("bp next grant", 32'(grant_id), 1);
        tick();
        chk("bp end idle", 32'(utx_valid), 0);

        // Message locking
        rst_pulse();
        src0.push_back({1'b0, 8'hA0});
        src0.push_back({1'b0, 8'hA1});
        src0.push_back({1'b1, 8'hA2});
        src1.push_back({1'b1, 8'hB0});
`ifdef SVC_UART_TX_ARB_LOCK_EN
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hA2});
        exp_q.push_back({1'b1, 8'hB0});
`else
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hA2});
`endif
        drive();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lock busy", 32'(busy), 1);
        end
        tick();
        chk("lock busy end", 32'(busy), 0);

        // Reset in the middle of a message from req1
        rst_pulse();
        src1.push_back({1'b0, 8'hC0});
        src1.push_back({1'b0, 8'hC1});
        src1.push_back({1'b1, 8'hC2});
        drive();
        #1;
        chk("rlock first ready", 32'(req_ready), 32'h2);
        tick();
`ifdef SVC_UART_TX_ARB_LOCK_EN
        en = 2'b01;
        src0.push_back({1'b1, 8'hD0});
        drive();
        #1;
        chk("rlock stall ready", 32'(req_ready), 0);
        chk("rlock stall busy", 32'(busy), 1);
`endif
        // C0 never handshakes: reset lands before the edge that would drain it
        rst_n = 1'b0;
        #1;
        chk("rlock utx_valid", 32'(utx_valid), 0);
        chk("rlock busy", 32'(busy), 0);
        chk("rlock req_ready", 32'(req_ready), 0);
        src0.delete();
        src1.delete();
        en = 2'b11;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        src0.push_back({1'b1, 8'hE0});
        src1.push_back({1'b1, 8'hF0});
        exp_q.push_back({1'b0, 8'hE0});
        exp_q.push_back({1'b1, 8'hF0});
        drive();
        #1;
        chk("rlock req0 first", 32'(req_ready), 32'h1);
        drain("rlock");
        tick();

        chk("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
